daq_cmd_sequencer: RTL and testbench
====================================

// Module: daq_cmd_sequencer
// PURPOSE
//  Parametrised instruction sequencer between the host instruction FIFO and the SPI peripheral masters (DAC, ADC).
//  - Decodes 32-bit instructions and performs writes/reads on internal registers, DAC and ADC.
//  - Unlike the first generation, it supports ADC write/read, throttles readback on readback_ready,
//    and replaces fixed delay stages with bounded SPI handshakes that carry error reporting.
// PARAMETERS
//  NUM_REGS       16    internal register count; power of 2, 2..16; AW = $clog2(NUM_REGS)
//  REG_W          16    internal register width; AW+REG_W <= 20
//  START_TIMEOUT  7     max cycles from req pulse to spi_busy rise
//  SPI_TIMEOUT    4095  max cycles spi_busy may stay high
// PORTS
//  clk              in   1   50 MHz system clock
//  reset            in   1   asynchronous, active-high
//  instr_ready      in   1   instruction FIFO non-empty
//  instr_ack        out  1   1-cycle pop strobe to the instruction FIFO
//  instr_in         in   32  instruction word
//  readback_ready   in   1   readback FIFO can accept a word
//  readback_write   out  1   1-cycle push strobe to the readback FIFO
//  readback_data    out  32  readback word; valid only while readback_write=1
//  dac_request_write out 1   1-cycle DAC SPI write request
//  dac_address      out  5   DAC channel address
//  dac_data         out  12  DAC code
//  adc_request_write out 1   1-cycle ADC SPI write request
//  adc_request_read out  1   1-cycle ADC SPI read request
//  adc_address      out  16  ADC register address
//  adc_data         out  8   ADC write data
//  adc_data_readback in  8   ADC read result; valid after spi_busy falls
//  spi_busy         in   1   shared SPI master busy flag
//  err_flag         out  1   sticky error; cleared by CLR_ERR or reset
//  err_code         out  2   0 none, 1 start timeout, 2 busy timeout, 3 bad opcode/sel
//  cu_state         out  3   debug: FSM state encoding
// BEHAVIOUR
//  Reset: FSM to IDLE; all outputs 0; regs[] = 0; err_flag and err_code = 0.
//    Reset mid-operation aborts silently and no readback word is emitted.
//  Fields: op = instr[31:27] (NOOP=0, WRITE_REG=1, READ_REG=2, CLR_ERR=3); sel = instr[26:25] (ADC=0, DAC=1, INT=2).
//    INT:  addr = instr[24 -: AW]; data = instr[24-AW -: REG_W]
//    DAC:  addr = instr[24:20]; data = instr[15:4]
//    ADC:  addr = instr[24:9]; data = instr[8:1]
//  FSM states: IDLE -> DECODE -> {ISSUE -> WAIT_START -> WAIT_DONE} -> {READBACK} -> IDLE.
//  IDLE: if instr_ready=1, pulse instr_ack in the same cycle, latch instr_in, and go to DECODE.
//    Minimum of 1 idle cycle between instructions.
//  DECODE:
//    - NOOP: go to IDLE.
//    - CLR_ERR: clear err_flag and err_code, then go to IDLE.
//    - INT write: update the register and go to IDLE. Latency is 2 cycles after ack.
//    - INT read: load readback {zero-ext regs[addr]} and go to READBACK.
//    - DAC read: not supported; sets err_code=3.
//    - sel=3 or unknown op: set err_flag and err_code=3, then go to IDLE (READ emits 32'hEEEE_0003).
//  ISSUE: drive a 1-cycle request with the address and data; the other outputs return to 0 next cycle.
//  WAIT_START: wait for spi_busy=1.
//    - If it is not seen within START_TIMEOUT cycles, raise err code 1.
//    - spi_busy already high at ISSUE counts as started.
//  WAIT_DONE: wait for spi_busy=0.
//    - If it does not fall within SPI_TIMEOUT cycles, raise err code 2.
//    - On completion, an ADC read samples adc_data_readback into {24'h0, data}.
//  Errors: a timeout sets err_flag and latches err_code (first error wins until cleared).
//    READ then emits 32'hEEEE_000c (c = code); WRITE returns to IDLE.
//  READBACK: hold the word until readback_ready=1.
//    Then pulse readback_write for 1 cycle in that cycle and go to IDLE.
//    Waits indefinitely; no new instruction is accepted meanwhile.
//  Counters: saturating, width sized from the parameters; cleared on entry to each wait state.
// STRUCTURE
//  Shared package daq_cmd_pkg: opcode and sel constants, field positions, error codes, state enum.
//  Sub-module spi_handshake_timer: start and busy timeout counter; outputs done and timeout pulses.
//  Register file lives inline.
// TESTING
//  1. INT write 0x1234 to reg 5, then READ reg 5, readback_ready=1 -> readback 32'h0000_1234, ack-to-write <= 4 cycles.
//  2. DAC write addr 3, code 0xABC; spi_busy high 2 cycles after request for 20 cycles -> single pulse, addr 3, data 0xABC;
//     next instr_ack no earlier than busy fall +1.
//  3. ADC read addr 0x0102 with adc_data_readback=0x5A at busy fall -> readback 32'h0000_005A.
//  4. DAC write with spi_busy stuck 0 -> err_flag=1, err_code=1 after START_TIMEOUT; ADC read with busy stuck 1 -> readback 32'hEEEE_0001
//     (first error is held); CLR_ERR -> err_flag=0.
//  5. INT read with readback_ready=0 for 50 cycles, then 1 -> exactly one readback_write; instr_ready held high, no ack meanwhile.
//  6. Assert reset during WAIT_DONE -> all outputs 0 next cycle; no readback; regs cleared.

Source files
------------

// File: rtl/daq_cmd_pkg.sv
`default_nettype none
// ============================================================================
// daq_cmd_pkg : instruction field layout, opcodes, error codes, FSM states
// Rev 1.0
// ============================================================================
package daq_cmd_pkg;

    localparam logic [4:0] OP_NOOP      = 5'd0;
    localparam logic [4:0] OP_WRITE_REG = 5'd1;
    localparam logic [4:0] OP_READ_REG  = 5'd2;
    localparam logic [4:0] OP_CLR_ERR   = 5'd3;

    localparam logic [1:0] SEL_ADC = 2'd0;
    localparam logic [1:0] SEL_DAC = 2'd1;
    localparam logic [1:0] SEL_INT = 2'd2;

    localparam int OP_MSB       = 31;
    localparam int OP_LSB       = 27;
    localparam int SEL_MSB      = 26;
    localparam int SEL_LSB      = 25;
    localparam int FIELD_TOP    = 24;
    localparam int DAC_ADDR_MSB = 24;
    localparam int DAC_ADDR_LSB = 20;
    localparam int DAC_DATA_MSB = 15;
    localparam int DAC_DATA_LSB = 4;
    localparam int ADC_ADDR_MSB = 24;
    localparam int ADC_ADDR_LSB = 9;
    localparam int ADC_DATA_MSB = 8;
    localparam int ADC_DATA_LSB = 1;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_START_TO = 2'd1;
    localparam logic [1:0] ERR_BUSY_TO  = 2'd2;
    localparam logic [1:0] ERR_BAD_CMD  = 2'd3;

    localparam logic [15:0] ERR_WORD_TAG = 16'hEEEE;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DECODE     = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_READBACK   = 3'd5
    } cu_state_e;

    function automatic logic [31:0] err_word(input logic [1:0] code);
        return {ERR_WORD_TAG, 14'd0, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_handshake_timer.sv
`default_nettype none
// ============================================================================
// spi_handshake_timer : saturating counter bounding SPI start and busy phases
// Rev 1.0
// ============================================================================
module spi_handshake_timer #(
    parameter int START_TIMEOUT = 7,
    parameter int SPI_TIMEOUT   = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic wait_start_i,
    input  logic wait_done_i,
    input  logic spi_busy_i,
    output logic started_o,
    output logic done_o,
    output logic start_timeout_o,
    output logic busy_timeout_o
);

    localparam int MAX_TO = (START_TIMEOUT > SPI_TIMEOUT) ? START_TIMEOUT : SPI_TIMEOUT;
    localparam int CW     = $clog2(MAX_TO + 1);
    localparam logic [CW-1:0] START_LIM = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] BUSY_LIM  = CW'(SPI_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if ((wait_start_i || wait_done_i) && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds the number of wait cycles already spent before this one.
    assign started_o       = wait_start_i & spi_busy_i;
    assign done_o          = wait_done_i & ~spi_busy_i;
    assign start_timeout_o = wait_start_i & ~spi_busy_i & (cnt_q >= START_LIM);
    assign busy_timeout_o  = wait_done_i & spi_busy_i & (cnt_q >= BUSY_LIM);

endmodule
`default_nettype wire

// File: rtl/daq_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// daq_cmd_sequencer : decodes host instructions into register, DAC and ADC ops
// Rev 1.0
// ============================================================================
module daq_cmd_sequencer
    import daq_cmd_pkg::*;
#(
    parameter int NUM_REGS      = 16,
    parameter int REG_W         = 16,
    parameter int START_TIMEOUT = 7,
    parameter int SPI_TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_ready_i,
    output logic        instr_ack_o,
    input  logic [31:0] instr_in_i,
    input  logic        readback_ready_i,
    output logic        readback_write_o,
    output logic [31:0] readback_data_o,
    output logic        dac_request_write_o,
    output logic [4:0]  dac_address_o,
    output logic [11:0] dac_data_o,
    output logic        adc_request_write_o,
    output logic        adc_request_read_o,
    output logic [15:0] adc_address_o,
    output logic [7:0]  adc_data_o,
    input  logic [7:0]  adc_data_readback_i,
    input  logic        spi_busy_i,
    output logic        err_flag_o,
    output logic [1:0]  err_code_o,
    output logic [2:0]  cu_state_o
);

    localparam int AW           = $clog2(NUM_REGS);
    localparam int INT_DATA_MSB = FIELD_TOP - AW;

    cu_state_e   state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rb_q, rb_d;
    logic        err_flag_q, err_flag_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [REG_W-1:0] regs_q [NUM_REGS];

    logic        reg_we;
    logic        fail;
    logic [1:0]  fail_code;

    logic [4:0]       w_op;
    logic [1:0]       w_sel;
    logic             w_is_read;
    logic [AW-1:0]    w_int_addr;
    logic [REG_W-1:0] w_int_data;
    logic             w_unused_bit0;

    logic w_tmr_clr, w_started, w_done, w_start_to, w_busy_to;

    assign w_op          = instr_q[OP_MSB:OP_LSB];
    assign w_sel         = instr_q[SEL_MSB:SEL_LSB];
    assign w_is_read     = (w_op == OP_READ_REG);
    assign w_int_addr    = instr_q[FIELD_TOP -: AW];
    assign w_int_data    = instr_q[INT_DATA_MSB -: REG_W];
    assign w_unused_bit0 = instr_q[0];

    // Restart the count on entry to either wait state.
    assign w_tmr_clr = (state_q == ST_ISSUE) || ((state_q == ST_WAIT_START) && spi_busy_i);

    spi_handshake_timer #(
        .START_TIMEOUT (START_TIMEOUT),
        .SPI_TIMEOUT   (SPI_TIMEOUT)
    ) u_timer (
        .clk             (clk),
        .reset           (reset),
        .clr_i           (w_tmr_clr),
        .wait_start_i    (state_q == ST_WAIT_START),
        .wait_done_i     (state_q == ST_WAIT_DONE),
        .spi_busy_i      (spi_busy_i),
        .started_o       (w_started),
        .done_o          (w_done),
        .start_timeout_o (w_start_to),
        .busy_timeout_o  (w_busy_to)
    );

    always_comb begin
        state_d             = state_q;
        instr_d             = instr_q;
        rb_d                = rb_q;
        err_flag_d          = err_flag_q;
        err_code_d          = err_code_q;
        reg_we              = 1'b0;
        fail                = 1'b0;
        fail_code           = ERR_NONE;
        instr_ack_o         = 1'b0;
        readback_write_o    = 1'b0;
        readback_data_o     = '0;
        dac_request_write_o = 1'b0;
        dac_address_o       = '0;
        dac_data_o          = '0;
        adc_request_write_o = 1'b0;
        adc_request_read_o  = 1'b0;
        adc_address_o       = '0;
        adc_data_o          = '0;

        case (state_q)
            ST_IDLE: begin
                if (instr_ready_i) begin
                    instr_ack_o = 1'b1;
                    instr_d     = instr_in_i;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_op)
                    OP_NOOP: state_d = ST_IDLE;
                    OP_CLR_ERR: begin
                        err_flag_d = 1'b0;
                        err_code_d = ERR_NONE;
                        state_d    = ST_IDLE;
                    end
                    OP_WRITE_REG, OP_READ_REG: begin
                        case (w_sel)
                            SEL_INT: begin
                                if (w_is_read) begin
                                    rb_d    = 32'(regs_q[w_int_addr]);
                                    state_d = ST_READBACK;
                                end else begin
                                    reg_we  = 1'b1;
                                    state_d = ST_IDLE;
                                end
                            end
                            SEL_DAC: begin
                                if (w_is_read) begin
                                    fail      = 1'b1;
                                    fail_code = ERR_BAD_CMD;
                                end else begin
                                    state_d = ST_ISSUE;
                                end
                            end
                            SEL_ADC: state_d = ST_ISSUE;
                            default: begin
                                fail      = 1'b1;
                                fail_code = ERR_BAD_CMD;
                            end
                        endcase
                    end
                    default: begin
                        fail      = 1'b1;
                        fail_code = ERR_BAD_CMD;
                    end
                endcase
            end
            ST_ISSUE: begin
                if (w_sel == SEL_DAC) begin
                    dac_request_write_o = 1'b1;
                    dac_address_o       = instr_q[DAC_ADDR_MSB:DAC_ADDR_LSB];
                    dac_data_o          = instr_q[DAC_DATA_MSB:DAC_DATA_LSB];
                end else begin
                    adc_request_read_o  = w_is_read;
                    adc_request_write_o = ~w_is_read;
                    adc_address_o       = instr_q[ADC_ADDR_MSB:ADC_ADDR_LSB];
                    adc_data_o          = instr_q[ADC_DATA_MSB:ADC_DATA_LSB];
                end
                state_d = spi_busy_i ? ST_WAIT_DONE : ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (w_started) begin
                    state_d = ST_WAIT_DONE;
                end else if (w_start_to) begin
                    fail      = 1'b1;
                    fail_code = ERR_START_TO;
                end
            end
            ST_WAIT_DONE: begin
                if (w_done) begin
                    if (w_is_read) begin
                        rb_d    = {24'h0, adc_data_readback_i};
                        state_d = ST_READBACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (w_busy_to) begin
                    fail      = 1'b1;
                    fail_code = ERR_BUSY_TO;
                end
            end
            ST_READBACK: begin
                if (readback_ready_i) begin
                    readback_write_o = 1'b1;
                    readback_data_o  = rb_q;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // First error sticks; an erroring read reports the held code.
        if (fail) begin
            if (!err_flag_q) begin
                err_flag_d = 1'b1;
                err_code_d = fail_code;
            end
            if (w_is_read) begin
                rb_d    = err_word(err_code_d);
                state_d = ST_READBACK;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            rb_q       <= '0;
            err_flag_q <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rb_q       <= rb_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[w_int_addr] <= w_int_data;
        end
    end

    assign err_flag_o = err_flag_q;
    assign err_code_o = err_code_q;
    assign cu_state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_daq_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_daq_cmd_sequencer : directed self-checking bench for daq_cmd_sequencer
// Rev 1.0
// ============================================================================
module tb_daq_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_ready = 1'b0;
    logic        instr_ack;
    logic [31:0] instr_in = '0;
    logic        readback_ready = 1'b0;
    logic        readback_write;
    logic [31:0] readback_data;
    logic        dac_request_write;
    logic [4:0]  dac_address;
    logic [11:0] dac_data;
    logic        adc_request_write;
    logic        adc_request_read;
    logic [15:0] adc_address;
    logic [7:0]  adc_data;
    logic [7:0]  adc_data_readback = '0;
    logic        spi_busy = 1'b0;
    logic        err_flag;
    logic [1:0]  err_code;
    logic [2:0]  cu_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int ack_count = 0, ack_cyc = 0;
    int rbw_count = 0, rb_cyc = 0;
    int dac_count = 0, dac_cyc = 0;
    int adc_rd_count = 0;
    logic [31:0] last_rb = '0;
    logic [4:0]  last_dac_addr = '0;
    logic [11:0] last_dac_data = '0;
    logic [15:0] last_adc_addr = '0;

    daq_cmd_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .instr_ready_i       (instr_ready),
        .instr_ack_o         (instr_ack),
        .instr_in_i          (instr_in),
        .readback_ready_i    (readback_ready),
        .readback_write_o    (readback_write),
        .readback_data_o     (readback_data),
        .dac_request_write_o (dac_request_write),
        .dac_address_o       (dac_address),
        .dac_data_o          (dac_data),
        .adc_request_write_o (adc_request_write),
        .adc_request_read_o  (adc_request_read),
        .adc_address_o       (adc_address),
        .adc_data_o          (adc_data),
        .adc_data_readback_i (adc_data_readback),
        .spi_busy_i          (spi_busy),
        .err_flag_o          (err_flag),
        .err_code_o          (err_code),
        .cu_state_o          (cu_state)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobes are sampled mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (instr_ack) begin
            ack_count++;
            ack_cyc = cyc;
        end
        if (readback_write) begin
            rbw_count++;
            rb_cyc  = cyc;
            last_rb = readback_data;
        end
        if (dac_request_write) begin
            dac_count++;
            dac_cyc       = cyc;
            last_dac_addr = dac_address;
            last_dac_data = dac_data;
        end
        if (adc_request_read) begin
            adc_rd_count++;
            last_adc_addr = adc_address;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] w);
        int a0;
        int k;
        a0 = ack_count;
        k  = 0;
        instr_in    = w;
        instr_ready = 1'b1;
        while (ack_count == a0 && k < 50) begin
            cycles(1);
            k++;
        end
        instr_ready = 1'b0;
        chk(tag, 32'(ack_count - a0), 32'd1);
    endtask

    task automatic wait_rbw(input string tag, input int n0, input int lim);
        int k;
        k = 0;
        while (rbw_count == n0 && k < lim) begin
            cycles(1);
            k++;
        end
        chk(tag, 32'(rbw_count - n0), 32'd1);
    endtask

    localparam logic [31:0] I_WR_R5   = 32'h0CA2_4680;  // INT write reg5 = 0x1234
    localparam logic [31:0] I_RD_R5   = 32'h14A0_0000;  // INT read reg5
    localparam logic [31:0] I_DAC_WR  = 32'h0A30_ABC0;  // DAC addr 3 code 0xABC
    localparam logic [31:0] I_ADC_RD  = 32'h1002_0400;  // ADC read addr 0x0102
    localparam logic [31:0] I_CLR     = 32'h1800_0000;
    localparam logic [31:0] I_BAD_RD  = 32'h1600_0000;  // READ with sel=3

    initial begin
        int n0, a0, k, fall_cyc, lat;

        // Reset state
        cycles(3);
        chk("rst_ack", 32'(instr_ack), 32'd0);
        chk("rst_rbw", 32'(readback_write), 32'd0);
        chk("rst_dac_req", 32'(dac_request_write), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_state", 32'(cu_state), 32'd0);
        reset = 1'b0;
        cycles(2);

        // 1: INT write then read back
        readback_ready = 1'b1;
        push("t1_ack_wr", I_WR_R5);
        cycles(2);
        n0 = rbw_count;
        push("t1_ack_rd", I_RD_R5);
        wait_rbw("t1_rbw", n0, 20);
        chk("t1_data", last_rb, 32'h0000_1234);
        lat = rb_cyc - ack_cyc;
        chk("t1_latency_le4", 32'((lat >= 1) && (lat <= 4)), 32'd1);
        cycles(2);

        // 2: DAC write with a 20-cycle busy window
        n0 = dac_count;
        push("t2_ack", I_DAC_WR);
        k = 0;
        while (dac_count == n0 && k < 20) begin
            cycles(1);
            k++;
        end
        cycles(1);
        spi_busy    = 1'b1;
        a0          = ack_count;
        instr_in    = '0;
        instr_ready = 1'b1;
        cycles(20);
        chk("t2_no_ack_busy", 32'(ack_count - a0), 32'd0);
        spi_busy = 1'b0;
        fall_cyc = cyc;
        k = 0;
        while (ack_count == a0 && k < 20) begin
            cycles(1);
            k++;
        end
        instr_ready = 1'b0;
        chk("t2_ack_after_fall", 32'(ack_cyc >= fall_cyc + 1), 32'd1);
        chk("t2_dac_pulses", 32'(dac_count - n0), 32'd1);
        chk("t2_dac_addr", 32'(last_dac_addr), 32'd3);
        chk("t2_dac_data", 32'(last_dac_data), 32'hABC);
        chk("t2_err_flag", 32'(err_flag), 32'd0);
        cycles(3);

        // 3: ADC read
        adc_data_readback = 8'h5A;
        n0 = adc_rd_count;
        a0 = rbw_count;
        push("t3_ack", I_ADC_RD);
        k = 0;
        while (adc_rd_count == n0 && k < 20) begin
            cycles(1);
            k++;
        end
        spi_busy = 1'b1;
        cycles(5);
        spi_busy = 1'b0;
        wait_rbw("t3_rbw", a0, 20);
        chk("t3_data", last_rb, 32'h0000_005A);
        chk("t3_adc_addr", 32'(last_adc_addr), 32'h0102);
        cycles(2);

        // 4: start timeout, held error on busy timeout, clear
        push("t4_ack_dac", I_DAC_WR);
        k = 0;
        while (!err_flag && k < 40) begin
            cycles(1);
            k++;
        end
        chk("t4_err_flag", 32'(err_flag), 32'd1);
        chk("t4_err_code", 32'(err_code), 32'd1);
        lat = cyc - dac_cyc;
        chk("t4_start_to_window", 32'((lat >= 7) && (lat <= 9)), 32'd1);
        cycles(2);
        spi_busy = 1'b1;
        n0 = rbw_count;
        push("t4_ack_adc", I_ADC_RD);
        wait_rbw("t4_rbw", n0, 5000);
        chk("t4_err_word", last_rb, 32'hEEEE_0001);
        chk("t4_code_held", 32'(err_code), 32'd1);
        spi_busy = 1'b0;
        cycles(2);
        push("t4_ack_clr", I_CLR);
        cycles(2);
        chk("t4_clr_flag", 32'(err_flag), 32'd0);
        chk("t4_clr_code", 32'(err_code), 32'd0);

        // Bad select on a read
        n0 = rbw_count;
        push("bad_ack", I_BAD_RD);
        wait_rbw("bad_rbw", n0, 20);
        chk("bad_word", last_rb, 32'hEEEE_0003);
        chk("bad_code", 32'(err_code), 32'd3);
        cycles(2);

        // 5: readback throttled by readback_ready
        readback_ready = 1'b0;
        n0 = rbw_count;
        push("t5_ack", I_RD_R5);
        a0          = ack_count;
        instr_in    = '0;
        instr_ready = 1'b1;
        cycles(50);
        chk("t5_no_rbw", 32'(rbw_count - n0), 32'd0);
        chk("t5_no_ack", 32'(ack_count - a0), 32'd0);
        chk("t5_state_rb", 32'(cu_state), 32'd5);
        readback_ready = 1'b1;
        k = 0;
        while (ack_count == a0 && k < 20) begin
            cycles(1);
            k++;
        end
        instr_ready = 1'b0;
        chk("t5_one_rbw", 32'(rbw_count - n0), 32'd1);
        chk("t5_data", last_rb, 32'h0000_1234);
        chk("t5_ack_after_rb", 32'(ack_cyc > rb_cyc), 32'd1);
        cycles(3);

        // 6: reset in the middle of an ADC read
        n0 = adc_rd_count;
        push("t6_ack", I_ADC_RD);
        k = 0;
        while (adc_rd_count == n0 && k < 20) begin
            cycles(1);
            k++;
        end
        spi_busy = 1'b1;
        cycles(3);
        chk("t6_in_wait_done", 32'(cu_state), 32'd4);
        n0 = rbw_count;
        reset = 1'b1;
        #1;
        chk("t6_state", 32'(cu_state), 32'd0);
        chk("t6_err_flag", 32'(err_flag), 32'd0);
        chk("t6_err_code", 32'(err_code), 32'd0);
        chk("t6_rbw", 32'(readback_write), 32'd0);
        chk("t6_rb_data", readback_data, 32'd0);
        chk("t6_adc_rd", 32'(adc_request_read), 32'd0);
        spi_busy = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        chk("t6_no_readback", 32'(rbw_count - n0), 32'd0);
        push("t6_ack_rd", I_RD_R5);
        wait_rbw("t6_rbw_rd", n0, 20);
        chk("t6_reg_cleared", last_rb, 32'h0000_0000);
        cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
